// File: rtl/fir_test_sequencer.sv
// Self-test sequencer for the FIR datapath: streams a stimulus ROM into the FIR,
// delays the input strobe by the FIR latency and checks each output against an expected ROM.
module fir_test_sequencer #(
    parameter int NUM_SAMPLES = 16,
    parameter int FIR_LATENCY = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16
) (
    input  logic                     system1000,
    input  logic                     system1000_rst,
    input  logic                     start,
    input  logic                     abort,
    output logic [ADDR_W-1:0]        stim_addr,
    input  logic signed [DATA_W-1:0] stim_data,
    output logic signed [DATA_W-1:0] fir_in,
    output logic                     fir_in_valid,
    input  logic signed [DATA_W-1:0] fir_out,
    output logic [ADDR_W-1:0]        exp_addr,
    input  logic signed [DATA_W-1:0] exp_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [15:0]              err_count,
    output logic [ADDR_W-1:0]        first_err_idx
);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

    state_t                 state;
    logic [FIR_LATENCY-1:0] vld_sr;
    logic                   chk;
    logic                   mismatch;
    logic                   last_chk;
    logic [15:0]            err_next;

    // stim_addr doubles as the input index and exp_addr as the output index.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        chk      = vld_sr[FIR_LATENCY-1] && busy;
        mismatch = chk && (fir_out != exp_data);
        last_chk = chk && (exp_addr == LAST_IDX);
        err_next = err_count;
        if (mismatch && (err_count != 16'hFFFF)) begin
            err_next = err_count + 16'd1;
        end
        fir_in = fir_in_valid ? stim_data : '0;
    end

    always_ff @(posedge system1000) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (system1000_rst) begin
            state         <= IDLE;
            stim_addr     <= '0;
            exp_addr      <= '0;
            fir_in_valid  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            vld_sr        <= '0;
        end else begin
            done   <= 1'b0;
            vld_sr <= (vld_sr << 1) | FIR_LATENCY'(fir_in_valid);

            // A compare in the abort cycle still counts; abort only stops further work.
            if (chk) begin
                err_count <= err_next;
                if (mismatch && (err_count == '0)) begin
                    first_err_idx <= exp_addr;
                end
                exp_addr <= exp_addr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= FEED;
                        fir_in_valid  <= 1'b1;
                        busy          <= 1'b1;
                        stim_addr     <= '0;
                        exp_addr      <= '0;
                        err_count     <= '0;
                        pass          <= 1'b0;
                        first_err_idx <= '1;
                    end
                end
                FEED: begin
                    if (abort) begin
                        state        <= IDLE;
                        fir_in_valid <= 1'b0;
                        busy         <= 1'b0;
                        vld_sr       <= '0;
                    end else if (stim_addr == LAST_IDX) begin
                        state        <= FLUSH;
                        fir_in_valid <= 1'b0;
                    end else begin
                        stim_addr <= stim_addr + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        vld_sr <= '0;
                    end else if (last_chk) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_test_sequencer.sv
// Bench for fir_test_sequencer: a 3-tap FIR model and ROMs around two instances
// (16 samples / latency 4, and 1 sample / latency 1), table-driven plus random runs.
module tb_fir_test_sequencer;

    localparam int N  = 16;
    localparam int L  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic signed [15:0] fir_fn(input logic signed [15:0] x,
                                                  input logic signed [15:0] x1,
                                                  input logic signed [15:0] x2);
        return 16'(3 * x + 2 * x1 - x2);
    endfunction

    // ---------------- instance A: N=16, L=4 ----------------
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [AW-1:0]        stim_addr, exp_addr, first_err_idx;
    logic signed [DW-1:0] stim_data, fir_in, fir_out, exp_data;
    logic                 fir_in_valid, busy, done, pass;
    logic [15:0]          err_count;

    logic signed [DW-1:0] stim_rom [N];
    logic signed [DW-1:0] exp_rom  [N];
    logic signed [DW-1:0] golden   [N];

    assign stim_data = stim_rom[stim_addr[3:0]];
    assign exp_data  = exp_rom[exp_addr[3:0]];

    fir_test_sequencer #(.NUM_SAMPLES(N), .FIR_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .system1000(clk), .system1000_rst(rst), .start(start), .abort(abort),
        .stim_addr(stim_addr), .stim_data(stim_data), .fir_in(fir_in),
        .fir_in_valid(fir_in_valid), .fir_out(fir_out), .exp_addr(exp_addr),
        .exp_data(exp_data), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    // FIR model: history clears whenever the input strobe drops, output delayed L cycles.
    logic signed [DW-1:0] h1 = '0, h2 = '0;
    logic signed [DW-1:0] dl [L] = '{default: '0};
    always @(posedge clk) begin
        if (fir_in_valid) begin
            h1 <= fir_in;
            h2 <= h1;
        end else begin
            h1 <= '0;
            h2 <= '0;
        end
        dl[0] <= fir_in_valid ? fir_fn(fir_in, h1, h2) : 16'sd0;
        for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
    end
    assign fir_out = dl[L-1];

    // ---------------- instance B: N=1, L=1 ----------------
    logic                 start_b = 1'b0;
    logic                 abort_b = 1'b0;
    logic [AW-1:0]        stim_addr_b, exp_addr_b, first_err_idx_b;
    logic signed [DW-1:0] stim_b = '0, exp_b = '0;
    logic signed [DW-1:0] fir_in_b;
    logic signed [DW-1:0] fir_out_b = '0;
    logic                 fir_in_valid_b, busy_b, done_b, pass_b;
    logic [15:0]          err_count_b;

    fir_test_sequencer #(.NUM_SAMPLES(1), .FIR_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .system1000(clk), .system1000_rst(rst), .start(start_b), .abort(abort_b),
        .stim_addr(stim_addr_b), .stim_data(stim_b), .fir_in(fir_in_b),
        .fir_in_valid(fir_in_valid_b), .fir_out(fir_out_b), .exp_addr(exp_addr_b),
        .exp_data(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_count_b), .first_err_idx(first_err_idx_b)
    );

    always @(posedge clk) fir_out_b <= fir_in_valid_b ? fir_fn(fir_in_b, 16'sd0, 16'sd0) : 16'sd0;

    // ---------------- helpers ----------------
    task automatic load_roms(input logic [15:0] mask, input logic [15:0] flip);
        for (int k = 0; k < N; k++) stim_rom[k] = 16'($urandom);
        for (int k = 0; k < N; k++) begin
            golden[k]  = fir_fn(stim_rom[k], (k >= 1) ? stim_rom[k-1] : 16'sd0,
                                             (k >= 2) ? stim_rom[k-2] : 16'sd0);
            exp_rom[k] = mask[k] ? (golden[k] ^ flip) : golden[k];
        end
    endtask

    // Reference outcome: sample k is compared in cycle k+1+L; an abort in cycle a keeps compares up to a.
    task automatic predict(input int abort_rel, input int rst_rel,
                           output int e_err, output int e_first, output bit e_pass);
        e_err   = 0;
        e_first = 255;
        e_pass  = 1'b0;
        if (rst_rel > 0) return;
        for (int k = 0; k < N; k++) begin
            if (exp_rom[k] !== golden[k] && (abort_rel == 0 || k + 1 + L <= abort_rel)) begin
                if (e_err == 0) e_first = k;
                e_err++;
            end
        end
        e_pass = (abort_rel == 0) && (e_err == 0);
    endtask

    task automatic run_a(input string tag, input int abort_rel, input int rst_rel, input bit glitch,
                         input int e_err, input int e_first, input bit e_pass);
        int n_valid = 0, first_valid = -1, n_busy = 0, last_busy = 0;
        int n_done = 0, done_rel = -1, bad = 0;
        int stop, exp_valid, exp_busy;
        stop      = (abort_rel > 0) ? abort_rel : rst_rel;
        exp_valid = (stop > 0 && stop < N) ? stop : N;
        exp_busy  = (stop > 0 && stop < N + L) ? stop : N + L;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= N + L + 4; rel++) begin
            if (fir_in_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = rel;
                if (rel > N || fir_in !== stim_rom[rel-1] || stim_addr !== AW'(rel - 1)) bad++;
            end else if (fir_in !== 16'sd0) begin
                bad++;
            end
            if (busy) begin
                n_busy++;
                last_busy = rel;
            end
            if (done) begin
                n_done++;
                done_rel = rel;
            end
            if (rst_rel > 0 && rel == rst_rel + 1)
                check({tag, " reset_outputs"},
                      {stim_addr, exp_addr, fir_in_valid, busy, done, pass, err_count, first_err_idx},
                      {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'hFF});
            start = glitch && (rel == 3 || rel == 10);
            abort = (rel == abort_rel);
            rst   = (rel == rst_rel);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        check({tag, " valid_count"}, n_valid, exp_valid);
        check({tag, " valid_first"}, first_valid, 1);
        check({tag, " busy_count"}, n_busy, exp_busy);
        check({tag, " busy_last"}, last_busy, exp_busy);
        check({tag, " done_count"}, n_done, (stop > 0) ? 0 : 1);
        if (stop == 0) check({tag, " done_cycle"}, done_rel, N + L + 1);
        check({tag, " fir_in_stream"}, bad, 0);
        check({tag, " err_count"}, err_count, e_err);
        check({tag, " first_err_idx"}, first_err_idx, e_first);
        check({tag, " pass"}, pass, e_pass);
    endtask

    task automatic run_b(input string tag, input bit corrupt);
        int n_valid = 0, first_valid = -1, n_done = 0, done_rel = -1;
        stim_b = 16'($urandom);
        exp_b  = fir_fn(stim_b, 16'sd0, 16'sd0) ^ (corrupt ? 16'sh0004 : 16'sh0000);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int rel = 1; rel <= 5; rel++) begin
            if (fir_in_valid_b) begin
                n_valid++;
                if (first_valid < 0) first_valid = rel;
            end
            if (done_b) begin
                n_done++;
                done_rel = rel;
            end
            @(negedge clk);
        end
        check({tag, " valid_count"}, n_valid, 1);
        check({tag, " valid_first"}, first_valid, 1);
        check({tag, " done_count"}, n_done, 1);
        check({tag, " done_cycle"}, done_rel, 3);
        check({tag, " err_count"}, err_count_b, corrupt ? 1 : 0);
        check({tag, " first_err_idx"}, first_err_idx_b, corrupt ? 0 : 255);
        check({tag, " pass"}, pass_b, !corrupt);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] mask;
        logic [15:0] flip;
        int          abort_rel;
        int          rst_rel;
        bit          glitch;
        int          e_err;
        int          e_first;
        bit          e_pass;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int   e_err, e_first;
        bit   e_pass;
        logic [15:0] mask;
        int   a_rel;

        vecs[0] = '{16'h0000, 16'h0001, 0,  0,  1'b0, 0, 255, 1'b1}; // golden run
        vecs[1] = '{16'h0220, 16'h8000, 0,  0,  1'b0, 2, 5,   1'b0}; // entries 5, 9 (sign bit)
        vecs[2] = '{16'h0000, 16'h0001, 0,  0,  1'b1, 0, 255, 1'b1}; // start glitches
        vecs[3] = '{16'h0220, 16'h0001, 0,  0,  1'b1, 2, 5,   1'b0}; // glitches + errors
        vecs[4] = '{16'h0204, 16'h0001, 8,  0,  1'b0, 1, 2,   1'b0}; // abort at 8
        vecs[5] = '{16'h0000, 16'h0001, 0,  0,  1'b0, 0, 255, 1'b1}; // clean run after abort
        vecs[6] = '{16'h0002, 16'h0001, 0,  12, 1'b0, 0, 255, 1'b0}; // reset at 12
        vecs[7] = '{16'h0000, 16'h0001, 0,  0,  1'b0, 0, 255, 1'b1}; // clean run after reset
        vecs[8] = '{16'h8000, 16'h0001, 0,  0,  1'b0, 1, 15,  1'b0}; // last compare only
        vecs[9] = '{16'h0001, 16'h0001, 0,  0,  1'b0, 1, 0,   1'b0}; // first compare only

        for (int i = 0; i < N; i++) begin
            stim_rom[i] = '0;
            exp_rom[i]  = '0;
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a", {stim_addr, exp_addr, fir_in_valid, busy, done, pass, err_count, first_err_idx},
                         {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'hFF});
        check("reset_b", {fir_in_valid_b, busy_b, done_b, pass_b, err_count_b, first_err_idx_b},
                         {1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'hFF});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            load_roms(vecs[i].mask, vecs[i].flip);
            run_a($sformatf("vec%0d", i), vecs[i].abort_rel, vecs[i].rst_rel, vecs[i].glitch,
                  vecs[i].e_err, vecs[i].e_first, vecs[i].e_pass);
            repeat (2) @(negedge clk);
        end

        for (int r = 0; r < 6; r++) begin
            mask  = 16'($urandom);
            a_rel = (r >= 4) ? int'($urandom_range(1, N + L)) : 0;
            load_roms(mask, 16'h0001 << $urandom_range(0, 15));
            predict(a_rel, 0, e_err, e_first, e_pass);
            run_a($sformatf("rand%0d", r), a_rel, 0, 1'b0, e_err, e_first, e_pass);
            repeat (2) @(negedge clk);
        end

        run_b("short_clean", 1'b0);
        run_b("short_bad", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
